// File: rtl/mem_bus_arbiter_pkg.sv
// ============================================================================
// Module      : mem_bus_arbiter_pkg
// Description : Shared state encodings, grant IDs and winner selection for
//               the data-memory bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        AR_IDLE    = 2'd0,
        AR_BUSY_IF = 2'd1,
        AR_BUSY_ME = 2'd2
    } ar_state_e;

    typedef enum logic {
        AR_GNT_IF = 1'b0,
        AR_GNT_ME = 1'b1
    } ar_gnt_e;

    // The memory stage normally wins; fetch wins alone or once it has starved.
    function automatic ar_gnt_e ar_pick(input logic if_req, input logic me_req,
                                        input logic starved);
        if (if_req && (!me_req || starved)) begin
            return AR_GNT_IF;
        end
        return AR_GNT_ME;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_bus_arbiter_if.sv
// ============================================================================
// Module      : mem_bus_arbiter_if
// Description : Requester and slave-side bus signals of the arbiter. The
//               master modport is the arbiter's view, slave the environment's.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_bus_arbiter_if #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 32
);
    logic              ar_i_if_cyc;
    logic              ar_i_if_stb;
    logic [AWIDTH-1:0] ar_i_if_addr;
    logic              ar_o_if_ack;
    logic [DWIDTH-1:0] ar_o_if_rdata;
    logic              ar_o_if_stall;
    logic              ar_o_if_err;

    logic              ar_i_me_cyc;
    logic              ar_i_me_stb;
    logic              ar_i_me_we;
    logic [AWIDTH-1:0] ar_i_me_addr;
    logic [DWIDTH-1:0] ar_i_me_wdata;
    logic              ar_o_me_ack;
    logic [DWIDTH-1:0] ar_o_me_rdata;
    logic              ar_o_me_stall;
    logic              ar_o_me_err;

    logic              ar_o_cyc;
    logic              ar_o_stb;
    logic              ar_o_we;
    logic [AWIDTH-1:0] ar_o_addr;
    logic [DWIDTH-1:0] ar_o_wdata;
    logic              ar_i_ack;
    logic [DWIDTH-1:0] ar_i_rdata;

    modport master (
        input  ar_i_if_cyc, ar_i_if_stb, ar_i_if_addr,
        output ar_o_if_ack, ar_o_if_rdata, ar_o_if_stall, ar_o_if_err,
        input  ar_i_me_cyc, ar_i_me_stb, ar_i_me_we, ar_i_me_addr, ar_i_me_wdata,
        output ar_o_me_ack, ar_o_me_rdata, ar_o_me_stall, ar_o_me_err,
        output ar_o_cyc, ar_o_stb, ar_o_we, ar_o_addr, ar_o_wdata,
        input  ar_i_ack, ar_i_rdata
    );

    modport slave (
        output ar_i_if_cyc, ar_i_if_stb, ar_i_if_addr,
        input  ar_o_if_ack, ar_o_if_rdata, ar_o_if_stall, ar_o_if_err,
        output ar_i_me_cyc, ar_i_me_stb, ar_i_me_we, ar_i_me_addr, ar_i_me_wdata,
        input  ar_o_me_ack, ar_o_me_rdata, ar_o_me_stall, ar_o_me_err,
        input  ar_o_cyc, ar_o_stb, ar_o_we, ar_o_addr, ar_o_wdata,
        output ar_i_ack, ar_i_rdata
    );

endinterface

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Shares one data-memory port between fetch and memory stage
//               with fixed priority, starvation guard and ack timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_arbiter #(
    parameter int AWIDTH     = 5,
    parameter int DWIDTH     = 32,
    parameter int TIMEOUT    = 15,
    parameter int STARVE_MAX = 3
) (
    input  wire logic         ar_clk,
    input  wire logic         ar_rst,
    mem_bus_arbiter_if.master bus
);
    import mem_bus_arbiter_pkg::*;

    localparam int WAIT_W   = $clog2(TIMEOUT);
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    localparam logic [WAIT_W-1:0]   WAIT_LAST  = WAIT_W'(TIMEOUT - 1);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    ar_state_e             state_q, state_d;
    logic                  cyc_q, cyc_d;
    logic                  stb_q, stb_d;
    logic                  we_q, we_d;
    logic [AWIDTH-1:0]     addr_q, addr_d;
    logic [DWIDTH-1:0]     wdata_q, wdata_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic [STARVE_W-1:0]   starve_q, starve_d;
    ar_gnt_e               gnt;

    logic if_req, me_req, busy_if, busy_me, busy, own_cyc, ack_fwd, err_fwd;

    assign if_req  = bus.ar_i_if_cyc & bus.ar_i_if_stb;
    assign me_req  = bus.ar_i_me_cyc & bus.ar_i_me_stb;
    assign busy_if = (state_q == AR_BUSY_IF);
    assign busy_me = (state_q == AR_BUSY_ME);
    assign busy    = busy_if | busy_me;
    assign own_cyc = (busy_if & bus.ar_i_if_cyc) | (busy_me & bus.ar_i_me_cyc);

    // An aborted transaction must not report a timeout against a requester that has left.
    assign ack_fwd = busy & bus.ar_i_ack & ~ar_rst;
    assign err_fwd = busy & ~bus.ar_i_ack & own_cyc & (wait_q == WAIT_LAST) & ~ar_rst;

    assign bus.ar_o_if_ack   = ack_fwd & busy_if;
    assign bus.ar_o_me_ack   = ack_fwd & busy_me;
    assign bus.ar_o_if_err   = err_fwd & busy_if;
    assign bus.ar_o_me_err   = err_fwd & busy_me;
    assign bus.ar_o_if_rdata = bus.ar_o_if_ack ? bus.ar_i_rdata : '0;
    assign bus.ar_o_me_rdata = bus.ar_o_me_ack ? bus.ar_i_rdata : '0;
    assign bus.ar_o_if_stall = if_req & ~bus.ar_o_if_ack & ~bus.ar_o_if_err & ~ar_rst;
    assign bus.ar_o_me_stall = me_req & ~bus.ar_o_me_ack & ~bus.ar_o_me_err & ~ar_rst;

    assign bus.ar_o_cyc   = cyc_q;
    assign bus.ar_o_stb   = stb_q;
    assign bus.ar_o_we    = we_q;
    assign bus.ar_o_addr  = addr_q;
    assign bus.ar_o_wdata = wdata_q;

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        stb_d    = 1'b0;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wait_d   = wait_q;
        starve_d = starve_q;
        gnt      = AR_GNT_ME;

        case (state_q)
            AR_IDLE: begin
                if (if_req || me_req) begin
                    gnt    = ar_pick(if_req, me_req, starve_q == STARVE_LIM);
                    cyc_d  = 1'b1;
                    stb_d  = 1'b1;
                    wait_d = '0;
                    if (gnt == AR_GNT_IF) begin
                        state_d  = AR_BUSY_IF;
                        we_d     = 1'b0;
                        addr_d   = bus.ar_i_if_addr;
                        wdata_d  = '0;
                        starve_d = '0;
                    end else begin
                        state_d = AR_BUSY_ME;
                        we_d    = bus.ar_i_me_we;
                        addr_d  = bus.ar_i_me_addr;
                        wdata_d = bus.ar_i_me_wdata;
                        if (if_req) begin
                            starve_d = starve_q + STARVE_W'(1);
                        end
                    end
                end
            end
            AR_BUSY_IF, AR_BUSY_ME: begin
                // Ack, abort and timeout all close the cycle; ack takes precedence over err.
                if (bus.ar_i_ack || !own_cyc || (wait_q == WAIT_LAST)) begin
                    state_d = AR_IDLE;
                    cyc_d   = 1'b0;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d = AR_IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge ar_clk) begin
        if (ar_rst) begin
            state_q  <= AR_IDLE;
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wait_q   <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            stb_q    <= stb_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wait_q   <= wait_d;
            starve_q <= starve_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Directed bench for mem_bus_arbiter: single transactions from
//               a vector table, then priority, starvation, timeout, abort, reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_bus_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int TO = 15;
    localparam int SM = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

    mem_bus_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .TIMEOUT(TO), .STARVE_MAX(SM)) dut (
        .ar_clk (clk),
        .ar_rst (rst),
        .bus    (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        is_me;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] srdata;
        logic        exp_we;
        logic [4:0]  exp_addr;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drop_all();
        bus.ar_i_if_cyc = 1'b0;
        bus.ar_i_if_stb = 1'b0;
        bus.ar_i_me_cyc = 1'b0;
        bus.ar_i_me_stb = 1'b0;
        bus.ar_i_ack    = 1'b0;
        bus.ar_i_rdata  = '0;
    endtask

    task automatic run_vec(input vec_t v);
        if (v.is_me) begin
            bus.ar_i_me_cyc   = 1'b1;
            bus.ar_i_me_stb   = 1'b1;
            bus.ar_i_me_we    = v.we;
            bus.ar_i_me_addr  = v.addr;
            bus.ar_i_me_wdata = v.wdata;
        end else begin
            bus.ar_i_if_cyc  = 1'b1;
            bus.ar_i_if_stb  = 1'b1;
            bus.ar_i_if_addr = v.addr;
        end
        settle();
        chk("vec_stall_idle", v.is_me ? bus.ar_o_me_stall : bus.ar_o_if_stall, 1);
        tick();
        chk("vec_cyc", bus.ar_o_cyc, 1);
        chk("vec_stb", bus.ar_o_stb, 1);
        chk("vec_we", bus.ar_o_we, v.exp_we);
        chk("vec_addr", bus.ar_o_addr, v.exp_addr);
        chk("vec_wdata", bus.ar_o_wdata, v.exp_wdata);
        for (int d = 0; d < v.delay; d++) begin
            tick();
            chk("vec_stb_low", bus.ar_o_stb, 0);
            chk("vec_cyc_hold", bus.ar_o_cyc, 1);
        end
        bus.ar_i_ack   = 1'b1;
        bus.ar_i_rdata = v.srdata;
        settle();
        chk("vec_ack", v.is_me ? bus.ar_o_me_ack : bus.ar_o_if_ack, 1);
        chk("vec_other_ack", v.is_me ? bus.ar_o_if_ack : bus.ar_o_me_ack, 0);
        chk("vec_rdata", v.is_me ? bus.ar_o_me_rdata : bus.ar_o_if_rdata, v.exp_rdata);
        chk("vec_stall_acked", v.is_me ? bus.ar_o_me_stall : bus.ar_o_if_stall, 0);
        tick();
        drop_all();
        settle();
        chk("vec_cyc_end", bus.ar_o_cyc, 0);
        chk("vec_ack_end", v.is_me ? bus.ar_o_me_ack : bus.ar_o_if_ack, 0);
    endtask

    logic [4:0] starve_addr[4];

    initial begin
        vecs[0] = '{1'b1, 1'b1, 5'd10, 32'd14,         2, 32'h1111_1111,
                    1'b1, 5'd10, 32'd14,         32'h1111_1111};
        vecs[1] = '{1'b0, 1'b0, 5'd4,  32'd0,          0, 32'hCAFE_F00D,
                    1'b0, 5'd4,  32'd0,          32'hCAFE_F00D};
        vecs[2] = '{1'b1, 1'b0, 5'd31, 32'hDEAD_BEEF,  1, 32'h1234_5678,
                    1'b0, 5'd31, 32'hDEAD_BEEF,  32'h1234_5678};
        vecs[3] = '{1'b0, 1'b0, 5'd0,  32'd0,          3, 32'hA5A5_A5A5,
                    1'b0, 5'd0,  32'd0,          32'hA5A5_A5A5};
        starve_addr[0] = 5'd1;
        starve_addr[1] = 5'd2;
        starve_addr[2] = 5'd3;
        starve_addr[3] = 5'd21;

        drop_all();
        bus.ar_i_if_addr  = '0;
        bus.ar_i_me_we    = 1'b0;
        bus.ar_i_me_addr  = '0;
        bus.ar_i_me_wdata = '0;

        // Reset state, with a request and a stray ack present during reset
        rst = 1'b1;
        bus.ar_i_if_cyc = 1'b1;
        bus.ar_i_if_stb = 1'b1;
        bus.ar_i_ack    = 1'b1;
        tick();
        tick();
        chk("rst_cyc", bus.ar_o_cyc, 0);
        chk("rst_stb", bus.ar_o_stb, 0);
        chk("rst_we", bus.ar_o_we, 0);
        chk("rst_addr", bus.ar_o_addr, 0);
        chk("rst_wdata", bus.ar_o_wdata, 0);
        chk("rst_if_stall", bus.ar_o_if_stall, 0);
        chk("rst_if_ack", bus.ar_o_if_ack, 0);
        drop_all();
        rst = 1'b0;
        tick();

        // Ack while idle has no effect
        bus.ar_i_ack = 1'b1;
        settle();
        chk("idle_ack_if", bus.ar_o_if_ack, 0);
        chk("idle_ack_me", bus.ar_o_me_ack, 0);
        tick();
        chk("idle_ack_cyc", bus.ar_o_cyc, 0);
        drop_all();

        for (int i = 0; i < 4; i++) begin
            run_vec(vecs[i]);
        end

        // Simultaneous requests: memory stage first, fetch afterwards
        bus.ar_i_if_cyc = 1'b1; bus.ar_i_if_stb = 1'b1; bus.ar_i_if_addr = 5'd4;
        bus.ar_i_me_cyc = 1'b1; bus.ar_i_me_stb = 1'b1; bus.ar_i_me_we = 1'b0;
        bus.ar_i_me_addr = 5'd7;
        tick();
        chk("prio_addr_me", bus.ar_o_addr, 7);
        chk("prio_we_me", bus.ar_o_we, 0);
        chk("prio_if_stall", bus.ar_o_if_stall, 1);
        bus.ar_i_ack = 1'b1; bus.ar_i_rdata = 32'h77;
        settle();
        chk("prio_me_ack", bus.ar_o_me_ack, 1);
        chk("prio_if_ack0", bus.ar_o_if_ack, 0);
        chk("prio_if_stall2", bus.ar_o_if_stall, 1);
        tick();
        bus.ar_i_me_cyc = 1'b0; bus.ar_i_me_stb = 1'b0; bus.ar_i_ack = 1'b0;
        settle();
        chk("prio_idle_cyc", bus.ar_o_cyc, 0);
        chk("prio_idle_if_stall", bus.ar_o_if_stall, 1);
        tick();
        chk("prio_addr_if", bus.ar_o_addr, 4);
        chk("prio_stb_if", bus.ar_o_stb, 1);
        bus.ar_i_ack = 1'b1; bus.ar_i_rdata = 32'h44;
        settle();
        chk("prio_if_ack", bus.ar_o_if_ack, 1);
        chk("prio_if_rdata", bus.ar_o_if_rdata, 32'h44);
        tick();
        drop_all();

        // Starvation guard: me, me, me, then fetch
        bus.ar_i_if_cyc = 1'b1; bus.ar_i_if_stb = 1'b1; bus.ar_i_if_addr = 5'd21;
        bus.ar_i_me_cyc = 1'b1; bus.ar_i_me_stb = 1'b1; bus.ar_i_me_we = 1'b1;
        bus.ar_i_me_addr = 5'd1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("starve_stb", bus.ar_o_stb, 1);
            chk("starve_addr", bus.ar_o_addr, starve_addr[k]);
            chk("starve_we", bus.ar_o_we, (k < 3) ? 1 : 0);
            bus.ar_i_ack = 1'b1;
            settle();
            chk("starve_grant_me", bus.ar_o_me_ack, (k < 3) ? 1 : 0);
            chk("starve_grant_if", bus.ar_o_if_ack, (k < 3) ? 0 : 1);
            tick();
            bus.ar_i_ack = 1'b0;
            bus.ar_i_me_addr = 5'(k + 2);
        end
        bus.ar_i_if_cyc = 1'b0; bus.ar_i_if_stb = 1'b0;
        bus.ar_i_me_addr = 5'd4;
        tick();
        chk("starve_tail_addr", bus.ar_o_addr, 4);
        bus.ar_i_ack = 1'b1;
        settle();
        chk("starve_tail_ack", bus.ar_o_me_ack, 1);
        tick();
        drop_all();

        // Timeout: no slave ack
        bus.ar_i_me_cyc = 1'b1; bus.ar_i_me_stb = 1'b1; bus.ar_i_me_we = 1'b0;
        bus.ar_i_me_addr = 5'd9;
        for (int c = 1; c <= TO; c++) begin
            tick();
            chk("to_cyc", bus.ar_o_cyc, 1);
            chk("to_err", bus.ar_o_me_err, (c == TO) ? 1 : 0);
            chk("to_ack", bus.ar_o_me_ack, 0);
            chk("to_stall", bus.ar_o_me_stall, (c == TO) ? 0 : 1);
            if (c == TO) begin
                bus.ar_i_me_cyc = 1'b0;
                bus.ar_i_me_stb = 1'b0;
            end
        end
        tick();
        chk("to_cyc_end", bus.ar_o_cyc, 0);
        chk("to_err_end", bus.ar_o_me_err, 0);
        drop_all();

        // Abort: requester leaves two cycles into the transaction
        bus.ar_i_me_cyc = 1'b1; bus.ar_i_me_stb = 1'b1; bus.ar_i_me_addr = 5'd12;
        tick();
        chk("abort_cyc", bus.ar_o_cyc, 1);
        tick();
        tick();
        bus.ar_i_me_cyc = 1'b0; bus.ar_i_me_stb = 1'b0;
        settle();
        chk("abort_no_err", bus.ar_o_me_err, 0);
        tick();
        chk("abort_cyc_low", bus.ar_o_cyc, 0);
        bus.ar_i_ack = 1'b1; bus.ar_i_rdata = 32'h99;
        settle();
        chk("abort_late_ack", bus.ar_o_me_ack, 0);
        chk("abort_late_rdata", bus.ar_o_me_rdata, 0);
        tick();
        chk("abort_cyc_stays_low", bus.ar_o_cyc, 0);
        drop_all();

        // Reset in the middle of a fetch
        bus.ar_i_if_cyc = 1'b1; bus.ar_i_if_stb = 1'b1; bus.ar_i_if_addr = 5'd6;
        tick();
        chk("mrst_busy_cyc", bus.ar_o_cyc, 1);
        rst = 1'b1;
        bus.ar_i_ack = 1'b1;
        settle();
        chk("mrst_ack_forced", bus.ar_o_if_ack, 0);
        chk("mrst_stall_forced", bus.ar_o_if_stall, 0);
        tick();
        chk("mrst_cyc", bus.ar_o_cyc, 0);
        chk("mrst_stb", bus.ar_o_stb, 0);
        chk("mrst_err", bus.ar_o_if_err, 0);
        rst = 1'b0;
        bus.ar_i_ack = 1'b0;
        settle();
        chk("mrst_stall_back", bus.ar_o_if_stall, 1);
        tick();
        chk("mrst_regrant_addr", bus.ar_o_addr, 6);
        chk("mrst_regrant_stb", bus.ar_o_stb, 1);
        bus.ar_i_ack = 1'b1; bus.ar_i_rdata = 32'h600D;
        settle();
        chk("mrst_regrant_ack", bus.ar_o_if_ack, 1);
        chk("mrst_regrant_rdata", bus.ar_o_if_rdata, 32'h600D);
        tick();
        drop_all();
        settle();
        chk("mrst_final_cyc", bus.ar_o_cyc, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
